// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/ack ports of the fetch and MEM requesters plus the shared SRAM port.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_data_oe;
  logic        ram_oe;
  logic        ram_we;
  logic        stall_req;
  logic        busy;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_data, if_ack, mem_rdata, mem_ack, ram_addr, ram_wdata, ram_data_oe,
           ram_oe, ram_we, stall_req, busy
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_data, if_ack, mem_rdata, mem_ack, ram_addr, ram_wdata, ram_data_oe,
           ram_oe, ram_we, stall_req, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and MEM-stage accesses onto one SRAM port with alternating priority.
module mem_arbiter #(
  parameter int WRITE_WAIT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, DONE} state_t;
  localparam logic [2:0] LAST = 3'(WRITE_WAIT - 1);
  state_t      state, state_n;
  logic        last_mem, sel_mem, we_l, grant_mem, req;
  logic [2:0]  cnt;
  logic [15:0] addr_l, wdata_l, if_data_q, mem_rdata_q;
  always_comb begin
    req       = bus.if_req | bus.mem_req;
    grant_mem = bus.mem_req & (~bus.if_req | ~last_mem);
    state_n   = state;
    unique case (state)
      IDLE:     state_n = !req ? IDLE : (grant_mem & bus.mem_we) ? WR_SETUP : RD;
      RD:       state_n = DONE;
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: state_n = (cnt == LAST) ? DONE : WR_PULSE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_mem    <= 1'b0;
      sel_mem     <= 1'b0;
      we_l        <= 1'b0;
      cnt         <= 3'd0;
      addr_l      <= 16'h0000;
      wdata_l     <= 16'h0000;
      if_data_q   <= 16'h0000;
      mem_rdata_q <= 16'h0000;
    end else begin
      state <= state_n;
      cnt   <= (state == WR_PULSE) ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && req) begin
        last_mem <= grant_mem;
        sel_mem  <= grant_mem;
        we_l     <= grant_mem & bus.mem_we;
        addr_l   <= grant_mem ? bus.mem_addr : bus.if_addr;
        wdata_l  <= bus.mem_wdata;
      end
      if (state == RD && !sel_mem) if_data_q <= bus.ram_rdata;
      if (state == RD && sel_mem) mem_rdata_q <= bus.ram_rdata;
    end
  end
  assign bus.ram_addr    = addr_l;
  assign bus.ram_wdata   = wdata_l;
  assign bus.ram_oe      = (state == RD);
  assign bus.ram_we      = (state == WR_PULSE);
  assign bus.ram_data_oe = (state == WR_SETUP) | (state == WR_PULSE) | (state == DONE && we_l);
  assign bus.if_ack      = (state == DONE) & ~sel_mem;
  assign bus.mem_ack     = (state == DONE) & sel_mem;
  assign bus.if_data     = if_data_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.stall_req   = bus.if_req & ~bus.if_ack;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scoreboard bench for mem_arbiter with an SRAM model.
module tb_mem_arbiter;
  typedef struct {logic we; logic [15:0] d;} mexp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] sram [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] if_q[$];
  mexp_t mem_q[$];
  logic prev_if_ack = 1'b0;
  logic prev_mem_ack = 1'b0;
  mem_arbiter_if b ();
  mem_arbiter #(.WRITE_WAIT(2)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) if (b.ram_we) sram[b.ram_addr] <= b.ram_wdata;
  assign b.ram_rdata = sram[b.ram_addr];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    mexp_t m;
    chk("oe_we_excl", {31'd0, b.ram_oe & b.ram_we}, 0);
    chk("oe_doe_excl", {31'd0, b.ram_oe & b.ram_data_oe}, 0);
    chk("stall_req", {31'd0, b.stall_req}, {31'd0, b.if_req & ~b.if_ack});
    chk("if_ack_one_cycle", {31'd0, b.if_ack & prev_if_ack}, 0);
    chk("mem_ack_one_cycle", {31'd0, b.mem_ack & prev_mem_ack}, 0);
    chk("acks_exclusive", {31'd0, b.if_ack & b.mem_ack}, 0);
    if (b.if_ack) begin
      chk("if_ack_expected", {31'd0, if_q.size() != 0}, 1);
      if (if_q.size() != 0) chk("if_data", {16'd0, b.if_data}, {16'd0, if_q.pop_front()});
    end
    if (b.mem_ack) begin
      chk("mem_ack_expected", {31'd0, mem_q.size() != 0}, 1);
      if (mem_q.size() != 0) begin
        m = mem_q.pop_front();
        if (!m.we) chk("mem_rdata", {16'd0, b.mem_rdata}, {16'd0, m.d});
      end
    end
    prev_if_ack  = b.if_ack;
    prev_mem_ack = b.mem_ack;
  end
  task automatic do_reset();
    #1 rst = 1'b1;
    b.if_req = 1'b0;
    b.mem_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic if_proc(int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      int t;
      repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
      a = 16'($urandom_range(0, 63));
      b.if_addr = a;
      b.if_req = 1'b1;
      if_q.push_back(ref_mem[a]);
      t = 0;
      do begin @(negedge clk); t++; end while (!b.if_ack && t < 40);
      chk("if_timeout", {31'd0, b.if_ack}, 1);
      #1 b.if_req = 1'b0;
    end
  endtask
  task automatic mem_proc(int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a, d;
      logic w;
      int t;
      repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
      a = 16'h8000 + 16'($urandom_range(0, 63));
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      b.mem_addr = a;
      b.mem_wdata = d;
      b.mem_we = w;
      b.mem_req = 1'b1;
      if (w) begin
        ref_mem[a] = d;
        mem_q.push_back('{1'b1, 16'h0000});
      end else mem_q.push_back('{1'b0, ref_mem[a]});
      t = 0;
      do begin @(negedge clk); t++; end while (!b.mem_ack && t < 40);
      chk("mem_timeout", {31'd0, b.mem_ack}, 1);
      #1 b.mem_req = 1'b0;
    end
  endtask
  initial begin
    logic [15:0] v;
    int k, t;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      sram[i] = v;
      ref_mem[i] = v;
      v = 16'($urandom);
      sram[16'h8000 + i] = v;
      ref_mem[16'h8000 + i] = v;
    end
    sram[16'h0010] = 16'h4A21;
    ref_mem[16'h0010] = 16'h4A21;
    b.if_req = 1'b0; b.if_addr = 16'h0; b.mem_req = 1'b0; b.mem_we = 1'b0;
    b.mem_addr = 16'h0; b.mem_wdata = 16'h0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {b.if_data, b.mem_rdata}, 0);
    chk("rst_ram", {b.ram_addr, b.ram_wdata}, 0);
    chk("rst_strobes", {26'd0, b.ram_oe, b.ram_we, b.ram_data_oe, b.if_ack, b.mem_ack, b.busy}, 0);
    #1 b.if_req = 1'b1; b.if_addr = 16'h0010;
    if_q.push_back(ref_mem[16'h0010]);
    #1 chk("fetch_stall_pending", {31'd0, b.stall_req}, 1);
    @(negedge clk);
    chk("fetch_rd", {13'd0, b.ram_oe, b.ram_we, b.ram_data_oe, b.ram_addr}, {16'd4, 16'h0010});
    @(negedge clk);
    chk("fetch_ack", {13'd0, b.if_ack, b.stall_req, b.ram_oe, b.if_data}, {16'd4, 16'h4A21});
    #1 b.if_req = 1'b0;
    @(negedge clk);
    chk("fetch_hold", {14'd0, b.busy, b.if_ack, b.if_data}, {16'd0, 16'h4A21});
    #1 b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 16'h8000; b.mem_wdata = 16'hBEEF;
    ref_mem[16'h8000] = 16'hBEEF;
    mem_q.push_back('{1'b1, 16'h0000});
    @(negedge clk);
    chk("store_setup", {14'd0, b.ram_we, b.ram_data_oe, b.ram_addr}, {16'd1, 16'h8000});
    chk("store_setup_data", {16'd0, b.ram_wdata}, {16'd0, 16'hBEEF});
    @(negedge clk);
    chk("store_pulse1", {30'd0, b.ram_we, b.ram_data_oe}, 3);
    @(negedge clk);
    chk("store_pulse2", {30'd0, b.ram_we, b.ram_data_oe}, 3);
    @(negedge clk);
    chk("store_done", {29'd0, b.ram_we, b.ram_data_oe, b.mem_ack}, 3);
    chk("store_sram", {16'd0, sram[16'h8000]}, {16'd0, 16'hBEEF});
    #1 b.mem_req = 1'b0; b.mem_we = 1'b0;
    do_reset();
    b.if_req = 1'b1; b.if_addr = 16'h0005;
    b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 16'h8001;
    for (int i = 0; i < 3; i++) begin
      if_q.push_back(ref_mem[16'h0005]);
      mem_q.push_back('{1'b0, ref_mem[16'h8001]});
    end
    k = 0; t = 0;
    while (k < 6 && t < 60) begin
      @(negedge clk);
      t++;
      if (b.if_ack | b.mem_ack) begin
        chk("alt_order", {31'd0, b.mem_ack}, {31'd0, k % 2 == 0});
        k++;
      end
    end
    chk("alt_count", k, 6);
    #1 b.if_req = 1'b0; b.mem_req = 1'b0;
    @(negedge clk);
    #1 b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 16'h0020;
    mem_q.push_back('{1'b0, ref_mem[16'h0020]});
    @(negedge clk);
    chk("rd_addr", {15'd0, b.ram_oe, b.ram_addr}, {16'd1, 16'h0020});
    #1 b.mem_addr = 16'h0030;
    @(negedge clk);
    chk("rd_change_ack", {15'd0, b.mem_ack, b.mem_rdata}, {16'd1, ref_mem[16'h0020]});
    #1 b.mem_req = 1'b0;
    @(negedge clk);
    #1 b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 16'h9000; b.mem_wdata = 16'h1234;
    repeat (2) @(negedge clk);
    chk("abort_in_pulse", {31'd0, b.ram_we}, 1);
    #1 rst = 1'b1; b.mem_req = 1'b0; b.mem_we = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {26'd0, b.busy, b.ram_we, b.ram_oe, b.ram_data_oe, b.mem_ack, b.if_ack}, 0);
    chk("abort_ram", {b.ram_addr, b.ram_wdata}, 0);
    chk("abort_data", {b.if_data, b.mem_rdata}, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    fork
      if_proc(40);
      mem_proc(40);
    join
    repeat (4) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WRITE_WAIT, default 1, number of cycles ramWe_o is held high per write (legal 1..4).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ifReq_i  in  1  instruction-fetch read request, level, held until ifAck_o seen.
REQ-005 ifAddr_i  in  16  fetch address.
REQ-006 ifData_o  out  16  fetched instruction, valid while ifAck_o high.
REQ-007 ifAck_o  out  1  one-cycle completion pulse for fetch.
REQ-008 memReq_i  in  1  MEM-stage access request, level, held until memAck_o seen.
REQ-009 memWe_i  in  1  1 = store, 0 = load.
REQ-010 memAddr_i  in  16  load/store address.
REQ-011 memWData_i  in  16  store data.
REQ-012 memRData_o  out  16  load data, valid while memAck_o high.
REQ-013 memAck_o  out  1  one-cycle completion pulse for MEM access.
REQ-014 ramAddr_o  out  16 / ramData_o  out  16 / ramDataOe_o  out  1 (drive data bus) / ramData_i  in  16 / ramOe_o  out  1 / ramWe_o  out  1  single shared SRAM port, strobes active-high.
REQ-015 stallReq_o  out  1  combinational ifReq_i & ~ifAck_o, to freeze PC/IF-ID.
REQ-016 busy_o  out  1  high whenever FSM not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, DONE.
REQ-018 IDLE: no request -> stay; arbitration winner's address/data/direction/port id latched at the edge, -> RD (read) or WR_SETUP (store).
REQ-019 Arbitration: only one requesting -> it wins; both requesting -> MEM wins unless lastGrant==MEM, then IF wins; lastGrant updated on every acceptance.
REQ-020 Request inputs SHALL be ignored outside IDLE; latched values drive the access to completion.
REQ-021 RD (1 cycle): ramAddr_o=latched addr, ramOe_o=1, ramWe_o=0, ramDataOe_o=0; ramData_i captured at the edge ending RD; -> DONE.
REQ-022 WR_SETUP (1 cycle): ramAddr_o, ramData_o driven, ramDataOe_o=1, ramWe_o=0; -> WR_PULSE.
REQ-023 WR_PULSE: ramWe_o=1 for exactly WRITE_WAIT cycles (internal counter), addr/data/ramDataOe_o held; -> DONE.
REQ-024 DONE (1 cycle): ack of served port =1, other ack =0; for reads captured data on ifData_o or memRData_o; for writes ramDataOe_o=1, ramWe_o=0, addr/data held (hold time); -> IDLE unconditionally.
REQ-025 Read latency: accept edge -> RD -> ack in DONE = ack 2 cycles after accepting edge; store ack WRITE_WAIT+2 cycles after.
REQ-026 ifData_o/memRData_o SHALL hold last captured value after ack; only the served port's register updates.
REQ-027 ramOe_o and ramWe_o SHALL never be high in the same cycle; ramOe_o SHALL never be high while ramDataOe_o high.
REQ-028 IDLE/DONE: ramOe_o=0, ramWe_o=0; ramDataOe_o=0 in IDLE.
REQ-029 A requester holding req through DONE SHALL not be re-served: DONE always passes through IDLE, where the requester has dropped req.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, lastGrant=IF, counter=0, all outputs 0 (ifData_o, memRData_o, ramAddr_o, ramData_o=16'h0000), regardless of state.
REQ-031 Reset mid-access SHALL abort the access with no ack and ramWe_o low from the next cycle; aborted store outcome undefined.

Verification
REQ-032 Fetch only: ifReq_i=1, ifAddr_i=16'h0010, SRAM[0x0010]=16'h4A21 -> ramOe_o high 1 cycle, ifAck_o pulse 2 cycles after accept, ifData_o=16'h4A21, stallReq_o low only in ack cycle.
REQ-033 Store, WRITE_WAIT=2: memAddr_i=16'h8000, memWData_i=16'hBEEF -> WR_SETUP 1 cycle, ramWe_o high exactly 2 cycles, memAck_o 4 cycles after accept, SRAM[0x8000]=16'hBEEF.
REQ-034 Simultaneous ifReq_i and memReq_i (load) from reset -> MEM served first, IF next; held continuously -> grants alternate IF/MEM, neither starves.
REQ-035 Inputs changed during RD (memAddr_i 0x0020->0x0030) -> access completes to 0x0020.
REQ-036 rst asserted during WR_PULSE -> next cycle IDLE, ramWe_o=0, no memAck_o, all outputs 0.
REQ-037 Protocol checker throughout: REQ-027 exclusions never violated, each ack exactly one cycle.
